// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with PC, branch target LUT and retire counter
module fetch_unit #(
   parameter int PC_W  = 10,
   parameter int KEY_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stall,
   input  logic             branch_en,
   input  logic [KEY_W-1:0] branch_key,
   input  logic             lut_we,
   input  logic [KEY_W-1:0] lut_waddr,
   input  logic [PC_W-1:0]  lut_wdata,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [8:0]       imem_data,
   output logic [8:0]       inst,
   output logic             inst_valid,
   output logic             done,
   output logic [15:0]      instr_count
);

   localparam logic [8:0] HALT = 9'h1FF;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_count;
   logic            r_done;
   logic [PC_W-1:0] r_lut [2**KEY_W];

   logic            w_run;
   logic            w_halt;
   logic            w_advance;
   logic [PC_W-1:0] w_next_pc;

   assign w_run     = (r_state == S_RUN);
   assign w_halt    = (imem_data == HALT);
   // An instruction retires only when running, not stalled and not the halt word.
   assign w_advance = w_run && !stall && !w_halt;
   // PC+1 wraps naturally at the PC width.
   assign w_next_pc = branch_en ? r_lut[branch_key] : r_pc + 1'b1;

   assign imem_addr   = r_pc;
   assign inst        = w_run ? imem_data : 9'h000;
   assign inst_valid  = w_advance;
   assign done        = r_done;
   assign instr_count = r_count;

   // Control FSM: owns state, PC, retire counter and the done flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_pc    <= '0;
                  r_count <= '0;
                  r_done  <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_advance) begin
                  r_pc <= w_next_pc;
                  if (r_count != 16'hFFFF) begin
                     r_count <= r_count + 16'd1;
                  end
               end else if (!stall && w_halt) begin
                  // Halt: PC stays on the halt word, any branch request is dropped.
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Branch target table: contents survive reset and are frozen while a program runs.
   always_ff @(posedge clk) begin
      if (lut_we && (r_state != S_RUN)) begin
         r_lut[lut_waddr] <= lut_wdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic       branch_en = 1'b0;
   logic [4:0] branch_key = '0;
   logic       lut_we = 1'b0;
   logic [4:0] lut_waddr = '0;
   logic [9:0] lut_wdata = '0;
   logic [9:0] imem_addr;
   logic [8:0] imem_data;
   logic [8:0] inst;
   logic       inst_valid;
   logic       done;
   logic [15:0] instr_count;

   logic [8:0]  rom [1024];
   logic [18:0] exp_q [$];
   logic [18:0] mon_exp;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_data = rom[imem_addr];

   fetch_unit #(.PC_W(10), .KEY_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .branch_en(branch_en), .branch_key(branch_key),
      .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .inst(inst), .inst_valid(inst_valid), .done(done),
      .instr_count(instr_count)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Push the expected retirement {addr, inst}, then run one cycle with the given branch request.
   task automatic retire(input logic br, input logic [4:0] key,
                         input logic [9:0] a, input logic [8:0] i);
      exp_q.push_back({a, i});
      branch_en  = br;
      branch_key = key;
      step();
      branch_en  = 1'b0;
   endtask

   task automatic lut_wr(input logic [4:0] k, input logic [9:0] d);
      lut_we    = 1'b1;
      lut_waddr = k;
      lut_wdata = d;
      step();
      lut_we    = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Monitor: every presented instruction must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (inst_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL retire_unexpected actual=%0h required=none", {imem_addr, inst});
            end else begin
               mon_exp = exp_q.pop_front();
               chk("retire", int'({imem_addr, inst}), int'(mon_exp));
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 1024; k++) rom[k] = 9'h000;
      rom[0] = 9'h010; rom[1] = 9'h011; rom[2] = 9'h012; rom[3] = 9'h1FF;

      // Asynchronous reset, checked before any clock edge.
      #1 reset = 1'b1;
      #1;
      chk("rst_addr", int'(imem_addr), 0);
      chk("rst_count", int'(instr_count), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_valid", int'(inst_valid), 0);
      chk("rst_inst", int'(inst), 0);
      step();
      step();
      reset = 1'b0;
      step();
      chk("idle_inst", int'(inst), 0);
      chk("idle_valid", int'(inst_valid), 0);

      // Straight-line program ending in HALT.
      pulse_start();
      chk("a_pc0", int'(imem_addr), 0);
      retire(1'b0, 5'h10, 10'd0, 9'h010);
      chk("a_pc1", int'(imem_addr), 1);
      retire(1'b0, 5'h11, 10'd1, 9'h011);
      chk("a_pc2", int'(imem_addr), 2);
      retire(1'b0, 5'h12, 10'd2, 9'h012);
      chk("a_pc3", int'(imem_addr), 3);
      chk("a_count3", int'(instr_count), 3);
      step();
      chk("a_done", int'(done), 1);
      chk("a_halt_pc", int'(imem_addr), 3);
      chk("a_final_count", int'(instr_count), 3);
      chk("a_done_inst", int'(inst), 0);
      chk("a_done_valid", int'(inst_valid), 0);

      // Branch program: LUT loaded while DONE.
      lut_wr(5'd5, 10'd10);
      lut_wr(5'd3, 10'd4);
      lut_wr(5'd6, 10'd1023);
      lut_wr(5'd0, 10'd20);
      rom[0] = 9'h020; rom[1] = 9'h021; rom[2] = 9'h005; rom[3] = 9'h000;
      rom[10] = 9'h043; rom[4] = 9'h006; rom[5] = 9'h045; rom[6] = 9'h046;
      rom[1023] = 9'h050; rom[20] = 9'h1FF;
      pulse_start();
      chk("b_restart_pc", int'(imem_addr), 0);
      chk("b_restart_count", int'(instr_count), 0);
      retire(1'b0, 5'h00, 10'd0, 9'h020);
      retire(1'b0, 5'h01, 10'd1, 9'h021);
      retire(1'b1, 5'h05, 10'd2, 9'h005);
      chk("b_br_target", int'(imem_addr), 10);
      chk("b_br_count", int'(instr_count), 3);
      retire(1'b1, 5'h03, 10'd10, 9'h043);
      chk("b_br_to4", int'(imem_addr), 4);
      stall = 1'b1;
      branch_en = 1'b1;
      branch_key = 5'h06;
      for (int s = 0; s < 3; s++) begin
         step();
         chk("b_stall_pc", int'(imem_addr), 4);
         chk("b_stall_count", int'(instr_count), 4);
      end
      stall = 1'b0;
      retire(1'b1, 5'h06, 10'd4, 9'h006);
      chk("b_after_stall_pc", int'(imem_addr), 1023);
      chk("b_after_stall_count", int'(instr_count), 5);
      retire(1'b0, 5'h10, 10'd1023, 9'h050);
      chk("b_wrap_pc", int'(imem_addr), 0);
      chk("b_wrap_count", int'(instr_count), 6);
      retire(1'b1, 5'h00, 10'd0, 9'h020);
      chk("b_to_halt_pc", int'(imem_addr), 20);
      branch_en = 1'b1;
      branch_key = 5'h05;
      step();
      branch_en = 1'b0;
      chk("b_halt_done", int'(done), 1);
      chk("b_halt_pc", int'(imem_addr), 20);
      chk("b_halt_count", int'(instr_count), 7);
      step();
      chk("b_done_hold_pc", int'(imem_addr), 20);
      pulse_start();
      chk("b_start_done_pc", int'(imem_addr), 0);
      chk("b_start_done_count", int'(instr_count), 0);
      chk("b_start_done_flag", int'(done), 0);

      // Running: LUT write and start must be ignored, then reset aborts.
      lut_we = 1'b1;
      lut_waddr = 5'd5;
      lut_wdata = 10'd7;
      retire(1'b0, 5'h00, 10'd0, 9'h020);
      lut_we = 1'b0;
      chk("c_pc1", int'(imem_addr), 1);
      start = 1'b1;
      retire(1'b0, 5'h01, 10'd1, 9'h021);
      start = 1'b0;
      chk("c_start_ignored", int'(imem_addr), 2);
      retire(1'b1, 5'h05, 10'd2, 9'h005);
      chk("c_lut_we_ignored", int'(imem_addr), 10);
      retire(1'b1, 5'h03, 10'd10, 9'h043);
      retire(1'b0, 5'h06, 10'd4, 9'h006);
      retire(1'b0, 5'h05, 10'd5, 9'h045);
      chk("c_pc6", int'(imem_addr), 6);
      chk("c_count6", int'(instr_count), 6);
      #1 reset = 1'b1;
      #1;
      chk("c_rst_addr", int'(imem_addr), 0);
      chk("c_rst_count", int'(instr_count), 0);
      chk("c_rst_inst", int'(inst), 0);
      chk("c_rst_valid", int'(inst_valid), 0);
      chk("c_rst_done", int'(done), 0);
      step();
      reset = 1'b0;
      step();
      step();
      chk("c_idle_addr", int'(imem_addr), 0);
      chk("c_idle_valid", int'(inst_valid), 0);
      chk("c_idle_inst", int'(inst), 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
